// File: rtl/cpu_pkg.sv
// Encodings and constants shared by the fetch stage, the hazard unit and the
// pipeline registers.
package cpu_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_J   = 2'b10,
    PCSRC_JR  = 2'b11
  } pcsrc_e;

  // 2'b11 is not a named code: pipeline registers treat it as hold.
  localparam logic [1:0] IFID_FLUSH = 2'b00;
  localparam logic [1:0] IFID_LOAD  = 2'b01;
  localparam logic [1:0] IFID_HOLD  = 2'b10;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/PC-source controls, redirect targets, the
// instruction-memory port and the IF/ID outputs.
interface if_stage_if;
  logic        PChazard;
  logic [1:0]  IFIDhazard;
  logic [1:0]  PCSrc;
  logic [31:0] BranchTarget;
  logic [31:0] JumpTarget;
  logic [31:0] RegTarget;
  logic [31:0] IFInst;
  logic [31:0] IFPC;
  logic [31:0] IDInst;
  logic [31:0] IDPCPlus4;
  logic        IDValid;
  logic [31:0] StallCount;
  logic [31:0] FlushCount;

  modport slave (
    input  PChazard, IFIDhazard, PCSrc, BranchTarget, JumpTarget, RegTarget, IFInst,
    output IFPC, IDInst, IDPCPlus4, IDValid, StallCount, FlushCount
  );

  modport master (
    output PChazard, IFIDhazard, PCSrc, BranchTarget, JumpTarget, RegTarget, IFInst,
    input  IFPC, IDInst, IDPCPlus4, IDValid, StallCount, FlushCount
  );
endinterface

// File: rtl/if_stage_ifid_reg.sv
// Pipeline register for instruction, PC+4 and valid with load/flush/hold
// control; the same pattern is reused for ID/EX.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] FLUSH_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  i_ctl,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_inst;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (reset || i_ctl == IFID_FLUSH) begin
      r_inst     <= FLUSH_INST;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else if (i_ctl == IFID_LOAD) begin
      r_inst     <= i_inst;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign o_inst     = r_inst;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and
// stall/flush performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.slave   bus
);
  import cpu_pkg::*;

  logic [31:0] r_pc;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;

  assign w_pc_plus4 = r_pc + 32'd4;

  // A redirect wins over PChazard: a branch resolving in EX raises both.
  always_comb begin
    w_pc_next = w_pc_plus4;
    case (bus.PCSrc)
      PCSRC_BR: w_pc_next = word_align(bus.BranchTarget);
      PCSRC_J:  w_pc_next = word_align(bus.JumpTarget);
      PCSRC_JR: w_pc_next = word_align(bus.RegTarget);
      default:  if (bus.PChazard) w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_stall_cnt <= 32'h0;
      r_flush_cnt <= 32'h0;
    end else begin
      r_pc <= w_pc_next;
      if (bus.IFIDhazard[1])
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.IFIDhazard == IFID_FLUSH)
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  ifid_reg #(.FLUSH_INST(NOP)) u_ifid (
    .clk        (clk),
    .reset      (reset),
    .i_ctl      (bus.IFIDhazard),
    .i_inst     (bus.IFInst),
    .i_pc_plus4 (w_pc_plus4),
    .o_inst     (bus.IDInst),
    .o_pc_plus4 (bus.IDPCPlus4),
    .o_valid    (bus.IDValid)
  );

  assign bus.IFPC       = r_pc;
  assign bus.StallCount = r_stall_cnt;
  assign bus.FlushCount = r_flush_cnt;

endmodule
